// File: rtl/wb_regfile.sv
// Writeback-stage register file: source select, 31 storage registers with
// x0 hard-wired to zero, write-through bypass on both read ports, and a
// counter of effective register writes.
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_i,
    input  logic [1:0]  MemToReg_i,
    input  logic [31:0] ALUresult_i,
    input  logic [31:0] readMem_i,
    input  logic [31:0] pcPlusFour_i,
    input  logic [31:0] Utype_res_i,
    input  logic [4:0]  wr_i,
    input  logic [4:0]  rr1_i,
    input  logic [4:0]  rr2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] wb_count_o
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned NREGS  = 32;

    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] wb_count_q;
    logic            wr_en;
    logic            byp1;
    logic            byp2;

    // An effective write needs a nonzero destination and no reset this cycle.
    assign wr_en = RegWrite_i && (wr_i != IDX_W'(0)) && !rst;
    assign byp1  = wr_en && (rr1_i == wr_i);
    assign byp2  = wr_en && (rr2_i == wr_i);

    // Writeback source select.
    always_comb begin
        wb_data_o = ALUresult_i;
        case (MemToReg_i)
            2'b00:   wb_data_o = ALUresult_i;
            2'b01:   wb_data_o = readMem_i;
            2'b10:   wb_data_o = pcPlusFour_i;
            2'b11:   wb_data_o = Utype_res_i;
            default: wb_data_o = ALUresult_i;
        endcase
    end

    // Register storage; reset wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= XLEN'(0);
            end
        end else if (wr_en) begin
            regs_q[wr_i] <= wb_data_o;
        end
    end

    // Effective-write counter, wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_count_q <= XLEN'(0);
        end else if (wr_en) begin
            wb_count_q <= wb_count_q + XLEN'(1);
        end
    end

    assign wb_count_o = wb_count_q;

    // Read ports: x0 reads zero, in-flight write bypasses storage.
    always_comb begin
        rd1_o = XLEN'(0);
        rd2_o = XLEN'(0);
        if (rr1_i != IDX_W'(0)) begin
            rd1_o = byp1 ? wb_data_o : regs_q[rr1_i];
        end
        if (rr2_i != IDX_W'(0)) begin
            rd2_o = byp2 ? wb_data_o : regs_q[rr2_i];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with hand-computed expectations.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        RegWrite_i;
    logic [1:0]  MemToReg_i;
    logic [31:0] ALUresult_i;
    logic [31:0] readMem_i;
    logic [31:0] pcPlusFour_i;
    logic [31:0] Utype_res_i;
    logic [4:0]  wr_i;
    logic [4:0]  rr1_i;
    logic [4:0]  rr2_i;
    logic [31:0] rd1_o;
    logic [31:0] rd2_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_count_o;

    int n_tests;
    int n_fail;

    wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .RegWrite_i   (RegWrite_i),
        .MemToReg_i   (MemToReg_i),
        .ALUresult_i  (ALUresult_i),
        .readMem_i    (readMem_i),
        .pcPlusFour_i (pcPlusFour_i),
        .Utype_res_i  (Utype_res_i),
        .wr_i         (wr_i),
        .rr1_i        (rr1_i),
        .rr2_i        (rr2_i),
        .rd1_o        (rd1_o),
        .rd2_o        (rd2_o),
        .wb_data_o    (wb_data_o),
        .wb_count_o   (wb_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input logic we, input logic [4:0] wr, input logic [1:0] sel,
                             input logic [31:0] alu);
        RegWrite_i  = we;
        wr_i        = wr;
        MemToReg_i  = sel;
        ALUresult_i = alu;
    endtask

    logic [31:0] exp_src [4];

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        RegWrite_i   = 1'b0;
        MemToReg_i   = 2'b00;
        ALUresult_i  = 32'h0;
        readMem_i    = 32'h0;
        pcPlusFour_i = 32'h0;
        Utype_res_i  = 32'h0;
        wr_i         = 5'd0;
        rr1_i        = 5'd0;
        rr2_i        = 5'd0;

        // Reset for one cycle, then every index reads zero.
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            rr1_i = 5'(i);
            rr2_i = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_x%0d", i), rd1_o, 32'h0);
            check($sformatf("reset_rd2_x%0d", 31 - i), rd2_o, 32'h0);
        end
        check("reset_count", wb_count_o, 32'h0);

        // Source select into x5 on consecutive cycles.
        ALUresult_i  = 32'h0000_0011;
        readMem_i    = 32'h0000_0022;
        pcPlusFour_i = 32'h0000_0033;
        Utype_res_i  = 32'h4400_0000;
        exp_src[0] = 32'h0000_0011;
        exp_src[1] = 32'h0000_0022;
        exp_src[2] = 32'h0000_0033;
        exp_src[3] = 32'h4400_0000;
        rr1_i = 5'd5;
        rr2_i = 5'd0;
        for (int k = 0; k < 4; k++) begin
            RegWrite_i = 1'b1;
            wr_i       = 5'd5;
            MemToReg_i = 2'(k);
            #1;
            check($sformatf("src_wbdata_%0d", k), wb_data_o, exp_src[k]);
            tick();
            RegWrite_i = 1'b0;
            #1;
            check($sformatf("src_x5_%0d", k), rd1_o, exp_src[k]);
        end
        check("src_count", wb_count_o, 32'd4);

        // No write: select changes must not alter state.
        RegWrite_i = 1'b0;
        MemToReg_i = 2'b01;
        tick();
        check("nowrite_count", wb_count_o, 32'd4);
        check("nowrite_x5", rd1_o, 32'h4400_0000);

        // Write to x0 is ignored and never bypasses.
        set_write(1'b1, 5'd0, 2'b00, 32'hDEAD_BEEF);
        rr1_i = 5'd0;
        rr2_i = 5'd5;
        #1;
        check("x0_rd1_pre", rd1_o, 32'h0);
        check("x0_rd2_pre", rd2_o, 32'h4400_0000);
        tick();
        RegWrite_i = 1'b0;
        #1;
        check("x0_rd1_post", rd1_o, 32'h0);
        check("x0_count", wb_count_o, 32'd4);
        check("x0_x5_hold", rd2_o, 32'h4400_0000);

        // Bypass: store x7=1 first.
        set_write(1'b1, 5'd7, 2'b00, 32'h0000_0001);
        tick();
        RegWrite_i = 1'b0;
        rr1_i = 5'd7;
        rr2_i = 5'd7;
        #1;
        check("byp_x7_stored", rd1_o, 32'h1);
        set_write(1'b1, 5'd7, 2'b00, 32'h0000_ABCD);
        #1;
        check("byp_rd1", rd1_o, 32'h0000_ABCD);
        check("byp_rd2", rd2_o, 32'h0000_ABCD);
        rr2_i = 5'd5;
        #1;
        check("byp_rd1_indep", rd1_o, 32'h0000_ABCD);
        check("byp_rd2_nobyp", rd2_o, 32'h4400_0000);
        tick();
        RegWrite_i = 1'b0;
        #1;
        check("byp_x7_after", rd1_o, 32'h0000_ABCD);
        check("byp_count", wb_count_o, 32'd6);

        // Store x3=0x12, then reset collides with a write of 0x55.
        set_write(1'b1, 5'd3, 2'b00, 32'h0000_0012);
        tick();
        check("rp_count_pre", wb_count_o, 32'd7);
        rst = 1'b1;
        set_write(1'b1, 5'd3, 2'b00, 32'h0000_0055);
        rr1_i = 5'd3;
        rr2_i = 5'd3;
        #1;
        check("rp_nobyp_rd1", rd1_o, 32'h0000_0012);
        check("rp_nobyp_rd2", rd2_o, 32'h0000_0012);
        tick();
        rst        = 1'b0;
        RegWrite_i = 1'b0;
        rr2_i      = 5'd5;
        #1;
        check("rp_x3", rd1_o, 32'h0);
        check("rp_x5", rd2_o, 32'h0);
        check("rp_count", wb_count_o, 32'h0);

        // Wrap: preload counter to all-ones, then one effective write.
        @(negedge clk);
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        set_write(1'b1, 5'd1, 2'b10, 32'h0);
        pcPlusFour_i = 32'h0000_0077;
        rr1_i = 5'd1;
        tick();
        RegWrite_i = 1'b0;
        #1;
        check("wrap_count", wb_count_o, 32'h0);
        check("wrap_x1", rd1_o, 32'h0000_0077);
        set_write(1'b1, 5'd31, 2'b11, 32'h0);
        rr2_i = 5'd31;
        tick();
        RegWrite_i = 1'b0;
        #1;
        check("wrap_count_next", wb_count_o, 32'd1);
        check("x31_write", rd2_o, 32'h4400_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The module SHALL have port RegWrite_i, input, 1 bit: writeback enable from the MEM/WB stage.
REQ-004 The module SHALL have port MemToReg_i, input, 2 bits: writeback source select.
REQ-005 The module SHALL have ports ALUresult_i, readMem_i, pcPlusFour_i and Utype_res_i, each input, 32 bits: the candidate writeback values.
REQ-006 The module SHALL have port wr_i, input, 5 bits: destination register index.
REQ-007 The module SHALL have ports rr1_i and rr2_i, each input, 5 bits: decode-stage read indices.
REQ-008 The module SHALL have ports rd1_o and rd2_o, each output, 32 bits: read data for rr1_i and rr2_i.
REQ-009 The module SHALL have port wb_data_o, output, 32 bits: the selected writeback value (combinational).
REQ-010 The module SHALL have port wb_count_o, output, 32 bits: the count of effective register writes.

Function
REQ-011 The module SHALL compute wb_data_o from MemToReg_i: 00 selects ALUresult_i, 01 readMem_i, 10 pcPlusFour_i, 11 Utype_res_i.
REQ-012 The module SHALL hold 31 storage registers x1..x31, each 32 bits; x0 SHALL have no storage.
REQ-013 An effective write SHALL be defined as RegWrite_i=1, wr_i!=0 and rst=0, sampled at a rising clk edge.
REQ-014 On an effective write, x[wr_i] SHALL take wb_data_o at that edge; all other registers SHALL hold.
REQ-015 RegWrite_i=1 with wr_i=0 SHALL modify no state and SHALL NOT increment wb_count_o.
REQ-016 Reads SHALL be combinational: rdN_o = 0 when rrN_i=0, otherwise x[rrN_i].
REQ-017 Write-through bypass: when an effective-write condition holds and rrN_i==wr_i!=0, rdN_o SHALL equal wb_data_o in the same cycle, before the edge.
REQ-018 Bypass SHALL apply independently to both read ports; rr1_i==rr2_i==wr_i SHALL give wb_data_o on both ports.
REQ-019 wb_count_o SHALL increment by 1 on each effective write, with 1-cycle latency (visible after the edge).
REQ-020 wb_count_o SHALL wrap from 0xFFFFFFFF to 0x00000000 with no flag.
REQ-021 X/unknown on MemToReg_i while RegWrite_i=0 SHALL have no effect on state.

Reset
REQ-022 When rst=1 at a rising clk edge, x1..x31 SHALL be cleared to 0 and wb_count_o SHALL be cleared to 0.
REQ-023 Reset SHALL take priority over a simultaneous write; the write SHALL be discarded.
REQ-024 While rst=1, bypass SHALL be disabled and rdN_o SHALL reflect stored contents (0 after the first reset edge).
REQ-025 Reset asserted mid-sequence SHALL take effect at the next edge only; combinational outputs SHALL change only as REQ-011/016/024 dictate.

Verification
REQ-026 Reset test: rst=1 for 1 cycle, then read all 32 indices -> every rd1_o/rd2_o = 0 and wb_count_o = 0.
REQ-027 Source select test: write x5 with MemToReg_i=00/01/10/11 on consecutive cycles, with ALU=0x11, mem=0x22, pc4=0x33, U=0x44000000 -> x5 reads 0x11, 0x22, 0x33, 0x44000000 after each edge; wb_count_o = 4.
REQ-028 x0 test: RegWrite_i=1, wr_i=0, ALUresult_i=0xDEADBEEF -> rd1_o(rr1_i=0)=0; wb_count_o unchanged; no bypass.
REQ-029 Bypass test: x7=0x1 stored; same cycle RegWrite_i=1, wr_i=7, ALU=0xABCD, rr1_i=rr2_i=7 -> rd1_o=rd2_o=0xABCD before the edge; x7=0xABCD after.
REQ-030 Reset-priority test: rst=1 with a write to x3=0x55 at the same edge -> x3=0, wb_count_o=0.
REQ-031 Wrap test: force 0xFFFFFFFF effective writes (or preload the counter via the bench) then 1 more write -> wb_count_o=0x00000000.
